// File: rtl/clock_ctrl.sv
// Control block for a digital clock: button conditioning, RUN/SET mode FSM,
// one-second tick prescaler and blink generator for the field being set.
module clock_ctrl #(
  parameter int TICK_DIV = 50_000_000,
  parameter int DB_LEN   = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       btn_mode,
  input  logic       btn_add,
  output logic       second,
  output logic       modify,
  output logic       add_hr,
  output logic       add_min,
  output logic       add_sec,
  output logic [1:0] mode,
  output logic       blink
);

  localparam int PW  = $clog2(TICK_DIV);
  localparam int BW  = $clog2(TICK_DIV / 2);
  localparam int DBW = $clog2(DB_LEN + 1);

  localparam logic [PW-1:0]  TICK_MAX = PW'(TICK_DIV - 1);
  localparam logic [BW-1:0]  HALF_MAX = BW'(TICK_DIV / 2 - 1);
  localparam logic [DBW-1:0] DB_MAX   = DBW'(DB_LEN);

  typedef enum logic [1:0] {
    RUN     = 2'd0,
    SET_HR  = 2'd1,
    SET_MIN = 2'd2,
    SET_SEC = 2'd3
  } state_e;

  // Bit 0 carries the mode button, bit 1 the add button.
  logic [1:0]     sync1_q, sync2_q, db_q, db_d, db_prev_q, press_q;
  logic [DBW-1:0] cnt_q [2];
  logic [DBW-1:0] cnt_d [2];

  state_e         state_q;
  logic [PW-1:0]  presc_q;
  logic [BW-1:0]  blink_cnt_q;
  logic           blink_q, second_q, modify_q;
  logic           add_hr_q, add_min_q, add_sec_q;

  logic           mode_press_s, add_press_s;

  function automatic state_e next_mode(input state_e s);
    case (s)
      RUN:     return SET_HR;
      SET_HR:  return SET_MIN;
      SET_MIN: return SET_SEC;
      default: return RUN;
    endcase
  endfunction

  // Debounce next-state: flip the level once the mismatch has lasted long enough.
  always_comb begin
    for (int i = 0; i < 2; i++) begin
      cnt_d[i] = {DBW{1'b0}};
      db_d[i]  = db_q[i];
      if (sync2_q[i] != db_q[i]) begin
        if (cnt_q[i] == DB_MAX) begin
          cnt_d[i] = {DBW{1'b0}};
          db_d[i]  = ~db_q[i];
        end else begin
          cnt_d[i] = cnt_q[i] + DBW'(1);
          db_d[i]  = db_q[i];
        end
      end else begin
        cnt_d[i] = {DBW{1'b0}};
        db_d[i]  = db_q[i];
      end
    end
  end

  // Synchronizers, debounced levels and rising-edge press pulses.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_q   <= 2'b00;
      sync2_q   <= 2'b00;
      db_q      <= 2'b00;
      db_prev_q <= 2'b00;
      press_q   <= 2'b00;
      cnt_q[0]  <= {DBW{1'b0}};
      cnt_q[1]  <= {DBW{1'b0}};
    end else begin
      sync1_q   <= {btn_add, btn_mode};
      sync2_q   <= sync1_q;
      db_q      <= db_d;
      db_prev_q <= db_q;
      press_q   <= db_q & ~db_prev_q;
      cnt_q[0]  <= cnt_d[0];
      cnt_q[1]  <= cnt_d[1];
    end
  end

  assign mode_press_s = press_q[0];
  assign add_press_s  = press_q[1];

  // Mode FSM with prescaler, blink timer and all registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= RUN;
      presc_q     <= {PW{1'b0}};
      blink_cnt_q <= {BW{1'b0}};
      blink_q     <= 1'b1;
      second_q    <= 1'b0;
      modify_q    <= 1'b0;
      add_hr_q    <= 1'b0;
      add_min_q   <= 1'b0;
      add_sec_q   <= 1'b0;
    end else begin
      add_hr_q  <= 1'b0;
      add_min_q <= 1'b0;
      add_sec_q <= 1'b0;
      second_q  <= 1'b0;
      if (mode_press_s) begin
        // A mode press wins over a coincident add press; timers restart.
        state_q     <= next_mode(state_q);
        modify_q    <= (next_mode(state_q) != RUN);
        presc_q     <= {PW{1'b0}};
        blink_cnt_q <= {BW{1'b0}};
        blink_q     <= 1'b1;
      end else if (state_q == RUN) begin
        modify_q    <= 1'b0;
        second_q    <= (presc_q == TICK_MAX);
        presc_q     <= (presc_q == TICK_MAX) ? {PW{1'b0}} : presc_q + PW'(1);
        blink_cnt_q <= {BW{1'b0}};
        blink_q     <= 1'b1;
      end else begin
        modify_q <= 1'b1;
        presc_q  <= {PW{1'b0}};
        if (blink_cnt_q == HALF_MAX) begin
          blink_cnt_q <= {BW{1'b0}};
          blink_q     <= ~blink_q;
        end else begin
          blink_cnt_q <= blink_cnt_q + BW'(1);
        end
        if (add_press_s) begin
          case (state_q)
            SET_HR:  add_hr_q  <= 1'b1;
            SET_MIN: add_min_q <= 1'b1;
            SET_SEC: add_sec_q <= 1'b1;
            default: add_hr_q  <= 1'b0;
          endcase
        end
      end
    end
  end

  assign mode    = state_q;
  assign modify  = modify_q;
  assign second  = second_q;
  assign blink   = blink_q;
  assign add_hr  = add_hr_q;
  assign add_min = add_min_q;
  assign add_sec = add_sec_q;

endmodule

// File: tb/tb_clock_ctrl.sv
// Self-checking bench for clock_ctrl with TICK_DIV=10, DB_LEN=4: a scoreboard
// of timed output events plus per-scenario level checks.
module tb_clock_ctrl;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       btn_mode = 1'b0;
  logic       btn_add = 1'b0;
  logic       second, modify, add_hr, add_min, add_sec, blink;
  logic [1:0] mode;

  int   cyc = 0;
  logic rst_s = 1'b1;
  int   checks = 0;
  int   errors = 0;

  // Event bits: [0] add_hr, [1] add_min, [2] add_sec, [3] second, [4] mode change.
  localparam logic [4:0] EV_HR   = 5'b00001;
  localparam logic [4:0] EV_MIN  = 5'b00010;
  localparam logic [4:0] EV_SEC  = 5'b00100;
  localparam logic [4:0] EV_TICK = 5'b01000;
  localparam logic [4:0] EV_MODE = 5'b10000;

  typedef struct packed {
    int         cyc;
    logic [4:0] ev;
    logic [1:0] md;
  } exp_t;

  exp_t exp_q[$];

  clock_ctrl #(.TICK_DIV(10), .DB_LEN(4)) dut (
    .clk(clk), .rst(rst), .btn_mode(btn_mode), .btn_add(btn_add),
    .second(second), .modify(modify), .add_hr(add_hr), .add_min(add_min),
    .add_sec(add_sec), .mode(mode), .blink(blink)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    cyc   <= cyc + 1;
    rst_s <= rst;
  end

  function automatic void push_exp(input int c, input logic [4:0] ev, input logic [1:0] md);
    exp_t e;
    int   k;
    e.cyc = c;
    e.ev  = ev;
    e.md  = md;
    k = 0;
    while (k < exp_q.size() && exp_q[k].cyc <= c) k++;
    exp_q.insert(k, e);
  endfunction

  task automatic monitor();
    logic [1:0] prev_mode;
    logic [4:0] ev;
    exp_t       e;
    prev_mode = 2'd0;
    forever begin
      @(negedge clk);
      if (rst_s) begin
        prev_mode = mode;
      end else begin
        while (exp_q.size() > 0 && exp_q[0].cyc < cyc) begin
          e = exp_q.pop_front();
          checks++; errors++;
          $display("FAIL missed_event cyc=%0d: nothing seen, expected ev=%b mode=%0d at cyc=%0d",
                   cyc, e.ev, e.md, e.cyc);
        end
        ev = {mode != prev_mode, second, add_sec, add_min, add_hr};
        if (ev != 5'b00000 || (exp_q.size() > 0 && exp_q[0].cyc == cyc)) begin
          checks++;
          if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL unexpected_event cyc=%0d: got ev=%b mode=%0d, expected none", cyc, ev, mode);
          end else begin
            e = exp_q.pop_front();
            if (e.cyc != cyc || e.ev !== ev || (ev[4] && e.md !== mode)) begin
              errors++;
              $display("FAIL event cyc=%0d: got ev=%b mode=%0d, expected ev=%b mode=%0d at cyc=%0d",
                       cyc, ev, mode, e.ev, e.md, e.cyc);
            end
          end
        end
        prev_mode = mode;
      end
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic check_empty(input string name);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL %s_pending: %0d events outstanding, expected 0", name, exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    checks++;
    if ({mode, modify, second, add_hr, add_min, add_sec, blink} !== 8'b0000_0001) begin
      errors++;
      $display("FAIL reset_state: mode=%0d modify=%b second=%b add=%b%b%b blink=%b, expected 0,0,0,000,1",
               mode, modify, second, add_hr, add_min, add_sec, blink);
    end
  endtask

  task automatic test_run();
    int c0;
    do_reset();
    c0 = cyc;
    push_exp(c0 + 10, EV_TICK, 2'd0);
    push_exp(c0 + 20, EV_TICK, 2'd0);
    push_exp(c0 + 30, EV_TICK, 2'd0);
    for (int i = 0; i < 36; i++) begin
      checks++;
      if (mode !== 2'd0 || modify !== 1'b0 || blink !== 1'b1) begin
        errors++;
        $display("FAIL run_levels i=%0d: mode=%0d modify=%b blink=%b, expected 0,0,1", i, mode, modify, blink);
      end
      @(negedge clk);
    end
    check_empty("run");
  endtask

  task automatic test_mode_cycle();
    int         c0;
    logic [1:0] em;
    do_reset();
    c0 = cyc;
    push_exp(c0 + 9,  EV_MODE, 2'd1);
    push_exp(c0 + 29, EV_MODE, 2'd2);
    push_exp(c0 + 49, EV_MODE, 2'd3);
    push_exp(c0 + 69, EV_MODE, 2'd0);
    push_exp(c0 + 79, EV_TICK, 2'd0);
    push_exp(c0 + 89, EV_TICK, 2'd0);
    for (int i = 0; i < 96; i++) begin
      btn_mode = (i < 80) && ((i % 20) < 10);
      em = (i < 9) ? 2'd0 : (i < 29) ? 2'd1 : (i < 49) ? 2'd2 : (i < 69) ? 2'd3 : 2'd0;
      checks++;
      if (mode !== em || modify !== (em != 2'd0) || (em != 2'd0 && second !== 1'b0)) begin
        errors++;
        $display("FAIL mode_cycle i=%0d: mode=%0d modify=%b second=%b, expected mode=%0d modify=%b",
                 i, mode, modify, second, em, em != 2'd0);
      end
      @(negedge clk);
    end
    check_empty("mode_cycle");
  endtask

  task automatic test_add_min();
    int   c0;
    logic eb;
    do_reset();
    c0 = cyc;
    push_exp(c0 + 9,  EV_MODE, 2'd1);
    push_exp(c0 + 29, EV_MODE, 2'd2);
    push_exp(c0 + 49, EV_MIN,  2'd2);
    push_exp(c0 + 69, EV_MIN,  2'd2);
    push_exp(c0 + 89, EV_MIN,  2'd2);
    for (int i = 0; i < 100; i++) begin
      btn_mode = (i < 10) || (i >= 20 && i < 30);
      btn_add  = (i >= 40) && (((i - 40) % 20) < 10);
      if (i >= 29) begin
        eb = (((i - 29) / 5) % 2) == 0;
        checks++;
        if (blink !== eb || mode !== 2'd2) begin
          errors++;
          $display("FAIL add_min_blink i=%0d: blink=%b mode=%0d, expected blink=%b mode=2", i, blink, mode, eb);
        end
      end
      @(negedge clk);
    end
    btn_add = 1'b0;
    check_empty("add_min");
  endtask

  task automatic test_bounce();
    int   c0;
    logic eb;
    do_reset();
    c0 = cyc;
    push_exp(c0 + 9,  EV_MODE, 2'd1);
    push_exp(c0 + 44, EV_HR,   2'd1);
    for (int i = 0; i < 60; i++) begin
      btn_mode = (i < 10);
      btn_add  = (i >= 20 && i < 23) || (i >= 35 && i < 45);
      if (i >= 9) begin
        eb = (((i - 9) / 5) % 2) == 0;
        checks++;
        if (blink !== eb || modify !== 1'b1) begin
          errors++;
          $display("FAIL bounce_levels i=%0d: blink=%b modify=%b, expected blink=%b modify=1", i, blink, modify, eb);
        end
      end
      @(negedge clk);
    end
    check_empty("bounce");
  endtask

  task automatic test_coincide();
    int c0;
    do_reset();
    c0 = cyc;
    push_exp(c0 + 9,  EV_MODE, 2'd1);
    push_exp(c0 + 29, EV_MODE, 2'd2);
    push_exp(c0 + 49, EV_MODE, 2'd3);
    push_exp(c0 + 69, EV_MODE, 2'd0);
    push_exp(c0 + 79, EV_TICK, 2'd0);
    push_exp(c0 + 89, EV_TICK, 2'd0);
    for (int i = 0; i < 96; i++) begin
      btn_mode = (i < 70) && ((i % 20) < 10);
      btn_add  = (i >= 60 && i < 70);
      @(negedge clk);
    end
    checks++;
    if (mode !== 2'd0 || modify !== 1'b0 || blink !== 1'b1) begin
      errors++;
      $display("FAIL coincide_final: mode=%0d modify=%b blink=%b, expected 0,0,1", mode, modify, blink);
    end
    check_empty("coincide");
  endtask

  task automatic test_reset_mid();
    int         c0;
    logic [1:0] em;
    do_reset();
    c0 = cyc;
    push_exp(c0 + 9,  EV_MODE, 2'd1);
    push_exp(c0 + 34, EV_TICK, 2'd0);
    push_exp(c0 + 44, EV_TICK, 2'd0);
    for (int i = 0; i < 50; i++) begin
      btn_mode = (i < 10);
      btn_add  = (i >= 20 && i < 30);
      rst      = (i == 23);
      em = (i >= 9 && i < 24) ? 2'd1 : 2'd0;
      checks++;
      if (mode !== em || modify !== (em != 2'd0) || (i >= 24 && blink !== 1'b1)) begin
        errors++;
        $display("FAIL reset_mid i=%0d: mode=%0d modify=%b blink=%b, expected mode=%0d modify=%b",
                 i, mode, modify, blink, em, em != 2'd0);
      end
      @(negedge clk);
    end
    check_empty("reset_mid");
  endtask

  task automatic test_held_reset();
    int c0;
    btn_mode = 1'b1;
    do_reset();
    c0 = cyc;
    push_exp(c0 + 9, EV_MODE, 2'd1);
    for (int i = 0; i < 30; i++) begin
      btn_mode = (i < 10);
      @(negedge clk);
    end
    checks++;
    if (mode !== 2'd1 || modify !== 1'b1) begin
      errors++;
      $display("FAIL held_reset_final: mode=%0d modify=%b, expected 1,1", mode, modify);
    end
    check_empty("held_reset");
  endtask

  initial begin
    fork
      monitor();
    join_none
    test_reset();
    test_run();
    test_mode_cycle();
    test_add_min();
    test_bounce();
    test_coincide();
    test_reset_mid();
    test_held_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
